// File: rtl/tree_sum_accumulator.sv
// Folds ACC_LEN consecutive valid adder-tree sums into one result and queues results in a show-ahead FIFO.
// Define ACCUM_SAT_EN to make the accumulator saturate at all-ones instead of wrapping.
module tree_sum_accumulator #(
  parameter int IN_WIDTH   = 14,
  parameter int ACC_LEN    = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [IN_WIDTH-1:0]       in_sum,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [$clog2(ACC_LEN):0]  out_count,
  output logic [$clog2(ACC_LEN):0]  group_cnt,
  output logic                      drop_err
);

  localparam int CNT_W = $clog2(ACC_LEN) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] next_acc;
  logic [CNT_W-1:0]     push_count;
  logic                 group_close;

  logic [ACC_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]     cnt_mem  [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr;
  logic [PTR_W:0]       rd_ptr;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;

  assign acc_base   = (group_cnt == '0) ? '0 : acc;
  assign addend     = in_valid ? ACC_WIDTH'(in_sum) : '0;
  assign push_count = group_cnt + CNT_W'(in_valid);

`ifdef ACCUM_SAT_EN
  logic [ACC_WIDTH:0] wide_sum;
  assign wide_sum = {1'b0, acc_base} + {1'b0, addend};
  assign next_acc = wide_sum[ACC_WIDTH] ? '1 : wide_sum[ACC_WIDTH-1:0];
`else
  assign next_acc = acc_base + addend;
`endif

  assign group_close = (in_valid && (group_cnt == LAST_CNT)) ||
                       (flush && ((group_cnt != '0) || in_valid));

  // Accumulator and open-group counter; acc after a close is never read because group_cnt==0 masks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      group_cnt <= '0;
    end else begin
      if (in_valid)
        acc <= next_acc;
      if (group_close)
        group_cnt <= '0;
      else if (in_valid)
        group_cnt <= group_cnt + CNT_ONE;
    end
  end

  // Extra pointer bit separates full from empty; a pop in the same cycle frees the slot for a push.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop     = !fifo_empty && out_ready;
  assign do_push    = group_close && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_err <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (group_close && !do_push)
        drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      data_mem[wr_ptr[PTR_W-1:0]] <= next_acc;
      cnt_mem[wr_ptr[PTR_W-1:0]]  <= push_count;
    end
  end

  // Head is masked to zero when empty so the storage itself needs no reset.
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : data_mem[rd_ptr[PTR_W-1:0]];
  assign out_count = fifo_empty ? '0 : cnt_mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Scoreboard bench for tree_sum_accumulator: directed groups, flush, backpressure, reset, and a
// narrow instance exercising wrap (or saturation when ACCUM_SAT_EN is defined).
module tb_tree_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [13:0] in_sum = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_count;
  logic [2:0]  group_cnt;
  logic        drop_err;

  logic        w_valid = 1'b0;
  logic [13:0] w_sum = '0;
  logic        w_flush = 1'b0;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [13:0] w_out_data;
  logic [1:0]  w_out_count;
  logic [1:0]  w_group_cnt;
  logic        w_drop_err;

  typedef struct {
    int data;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  tree_sum_accumulator #(
    .IN_WIDTH(14), .ACC_LEN(4), .ACC_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sum(in_sum), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .group_cnt(group_cnt), .drop_err(drop_err)
  );

  tree_sum_accumulator #(
    .IN_WIDTH(14), .ACC_LEN(2), .ACC_WIDTH(14), .FIFO_DEPTH(2)
  ) u_wrap (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_sum(w_sum), .flush(w_flush),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_count(w_out_count), .group_cnt(w_group_cnt), .drop_err(w_drop_err)
  );

  // Monitor: every accepted head is checked against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_output: got data=%0d count=%0d, expected no output",
                 out_data, out_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(out_data) != e.data || int'(out_count) != e.cnt) begin
          bad++;
          $display("[TB] FAIL scoreboard: got data=%0d count=%0d, expected data=%0d count=%0d",
                   out_data, out_count, e.data, e.cnt);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input int s, input logic f);
    in_valid = v;
    in_sum   = 14'(s);
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expectResult(input int d, input int c);
    exp_t e;
    e.data = d;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drainQueue(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_drain: got %0d results still pending, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_count", out_count, 0);
    checkOutput("reset_group_cnt", group_cnt, 0);
    checkOutput("reset_drop_err", drop_err, 0);

    // Wrap or saturation on the narrow instance
    w_valid = 1'b1;
    w_sum   = 14'd16383;
    @(posedge clk);
    #1;
    w_sum = 14'd2;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    checkOutput("wrap_out_valid", w_out_valid, 1);
`ifdef ACCUM_SAT_EN
    checkOutput("sat_out_data", w_out_data, 16383);
`else
    checkOutput("wrap_out_data", w_out_data, 1);
`endif
    checkOutput("wrap_out_count", w_out_count, 2);

    // Basic group with one-cycle output pulse
    out_ready = 1'b1;
    applyStimulus(1'b1, 10, 1'b0);
    applyStimulus(1'b1, 20, 1'b0);
    checkOutput("basic_group_cnt", group_cnt, 2);
    applyStimulus(1'b1, 30, 1'b0);
    expectResult(100, 4);
    applyStimulus(1'b1, 40, 1'b0);
    checkOutput("basic_latency_valid", out_valid, 1);
    checkOutput("basic_group_reopen", group_cnt, 0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("basic_pulse_len", out_valid, 0);
    drainQueue("basic");

    // Gapped input with garbage data while invalid
    applyStimulus(1'b1, 10, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 20, 1'b0);
    applyStimulus(1'b0, 999, 1'b0);
    applyStimulus(1'b0, 999, 1'b0);
    applyStimulus(1'b1, 30, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b0);
    expectResult(100, 4);
    applyStimulus(1'b1, 40, 1'b0);
    drainQueue("gapped");

    // Flush alone, flush with data, flush on empty group
    applyStimulus(1'b1, 5, 1'b0);
    applyStimulus(1'b1, 7, 1'b0);
    expectResult(12, 2);
    applyStimulus(1'b0, 0, 1'b1);
    drainQueue("flush_alone");
    applyStimulus(1'b1, 1, 1'b0);
    expectResult(4, 2);
    applyStimulus(1'b1, 3, 1'b1);
    drainQueue("flush_with_data");
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("flush_empty_no_push", out_valid, 0);
    checkOutput("flush_empty_group_cnt", group_cnt, 0);

    // Backpressure: single-input groups fill the FIFO, fifth is dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expectResult(i, 1);
      applyStimulus(1'b1, i, 1'b1);
      checkOutput("bp_head_held", out_data, 1);
    end
    checkOutput("bp_full_no_drop", drop_err, 0);
    applyStimulus(1'b1, 5, 1'b1);
    checkOutput("bp_drop_err", drop_err, 1);
    checkOutput("bp_head_after_drop", out_data, 1);
    out_ready = 1'b1;
    drainQueue("bp");
    checkOutput("bp_empty_after_drain", out_valid, 0);
    checkOutput("bp_drop_sticky", drop_err, 1);

    // Reset mid-group with results pending
    out_ready = 1'b0;
    applyStimulus(1'b1, 7, 1'b1);
    applyStimulus(1'b1, 8, 1'b1);
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    checkOutput("pre_reset_group_cnt", group_cnt, 2);
    checkOutput("pre_reset_out_valid", out_valid, 1);
    doReset();
    checkOutput("mid_reset_out_valid", out_valid, 0);
    checkOutput("mid_reset_group_cnt", group_cnt, 0);
    checkOutput("mid_reset_drop_err", drop_err, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1, 1'b0);
    expectResult(4, 4);
    applyStimulus(1'b1, 1, 1'b0);
    drainQueue("post_reset");

    // Push and pop on the same edge while full
    out_ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      expectResult(i, 1);
      applyStimulus(1'b1, i, 1'b1);
    end
    out_ready = 1'b1;
    expectResult(15, 1);
    applyStimulus(1'b1, 15, 1'b1);
    checkOutput("full_pushpop_no_drop", drop_err, 0);
    drainQueue("full_pushpop");
    checkOutput("full_pushpop_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tree_sum_accumulator.md
Name: tree_sum_accumulator

Overview:
- Sits directly downstream of the pipelined adder tree. Consumes its registered `sum` output and the matching `dout_valid` strobe.
- Accumulates ACC_LEN consecutive valid tree sums into one result, e.g. summing partial products across input channels or tiles.
- Buffers completed results in a small show-ahead FIFO and presents them on a valid/ready handshake.
- The tree has no backpressure, so this block accepts an input on every valid cycle without stalling.

Parameters:
- IN_WIDTH, 14: width of the tree sum input (unsigned).
- ACC_LEN, 4: number of valid inputs per accumulated result; legal range is 1 or more.
- ACC_WIDTH, 16: width of the accumulator and output. Must be at least IN_WIDTH + clog2(ACC_LEN) for lossless results.
- FIFO_DEPTH, 4: number of result entries; power of two, 2 or more.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: tree output valid (connects to the tree's dout_valid).
- in_sum, in, IN_WIDTH: tree sum (connects to the tree's sum).
- flush, in, 1: closes the current partial group early.
- out_valid, out, 1: FIFO head holds a result.
- out_ready, in, 1: consumer accepts the head.
- out_data, out, ACC_WIDTH: FIFO head result.
- out_count, out, clog2(ACC_LEN)+1: number of inputs folded into the head result.
- group_cnt, out, clog2(ACC_LEN)+1: inputs absorbed into the currently open group.
- drop_err, out, 1: sticky flag; a result was lost because the FIFO was full.

Behaviour:
- Reset values, applied at the clk edge while rst=1: acc=0, group_cnt=0, FIFO empty, out_valid=0, out_data=0, out_count=0, drop_err=0.
- Reset mid-group discards the partial sum. Reset with the FIFO non-empty discards all stored results.
- in_sum is zero-extended to ACC_WIDTH. All arithmetic is unsigned and wraps modulo 2^ACC_WIDTH.
- Next accumulator value: next_acc = (group_cnt==0 ? 0 : acc) + (in_valid ? in_sum : 0).
- Each in_valid cycle: acc <= next_acc and group_cnt increments.
- Group closes when either:
  - in_valid=1 and group_cnt==ACC_LEN-1, or
  - flush=1 and (group_cnt>0 or in_valid=1).
- On close:
  - push {next_acc, inputs-in-group} into the FIFO at that edge;
  - then group_cnt <= 0.
  - acc value after close is don't-care; the next group restarts from 0.
- flush with group_cnt==0 and in_valid=0 is a no-op: no push, no empty result.
- flush together with in_valid: the current in_sum is included, then the group closes.
- ACC_LEN=1: every valid input closes a group, so the block acts as a 1-cycle registered pass-through into the FIFO.
- Latency: out_valid rises 1 cycle after the edge at which the closing input is sampled, provided the FIFO was empty.
- FIFO is show-ahead:
  - out_data and out_count are valid whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle:
  - FIFO not full: both happen and occupancy is unchanged.
  - FIFO full: the pop frees a slot, so the push is accepted and nothing is dropped.
- Push when full with no pop: the result is discarded, drop_err <= 1, and FIFO contents are unchanged. drop_err clears only on rst.
- out_ready while empty: no effect.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished with an extra pointer bit.
- in_valid is never back-pressured; group_cnt and acc advance regardless of FIFO state.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined: the add saturates. If zero-extended acc + in_sum exceeds 2^ACC_WIDTH-1, next_acc is all-ones, and the group continues to saturate until it closes.
- Undefined: modulo wrap as above; no saturation logic is generated.

Test Plan:
- Basic group: ACC_LEN=4; in_sum 10, 20, 30, 40 on consecutive valid cycles, out_ready=1 → one cycle later out_valid=1 for exactly 1 cycle with out_data=100, out_count=4.
- Gapped input: the same four values separated by 0–3 idle cycles, plus in_sum=999 with in_valid=0 mid-group → out_data=100; the invalid data is ignored.
- Flush handling:
  - 2 inputs (5, 7), then flush alone → out_data=12, out_count=2;
  - flush with in_valid and in_sum=3 at group_cnt=1 after input 1 → out_data=4, out_count=2;
  - flush on an empty group → no push.
- Backpressure: out_ready=0, ACC_LEN=1, FIFO_DEPTH=4; inputs 1..5 →
  - out_valid=1 with out_data=1 held;
  - fifth result dropped and drop_err=1;
  - release out_ready → 1, 2, 3, 4 popped in order, then out_valid=0.
  - Repeat with pop and push on the same cycle while full → no drop.
- Wrap / saturation: IN_WIDTH=14, ACC_WIDTH=14, ACC_LEN=2; inputs 16383 and 2 → out_data=1 without the macro, 16383 with ACCUM_SAT_EN.
- Reset mid-operation: rst asserted after 2 of 4 inputs, with 2 FIFO entries pending → next cycle out_valid=0, group_cnt=0, drop_err=0; the next full group of 1, 1, 1, 1 yields out_data=4.
